// File: rtl/clk_freq_monitor.sv
// Core-clock frequency monitor and lock detector.
// Counts core cycles over REF_EDGES reference rising edges, checks each
// count against EXPECTED +/- TOLERANCE and derives locked / fault status.
// ref_in is asynchronous and is only ever sampled through the synchronizer.
module clk_freq_monitor #(
    parameter int REF_EDGES    = 32,
    parameter int EXPECTED     = 100,
    parameter int TOLERANCE    = 2,
    parameter int LOCK_WINDOWS = 4,
    parameter int CNT_WIDTH    = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ref_in,
    input  logic                 fault_clear,
    output logic                 locked,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] meas_count,
    output logic                 meas_valid
);

    localparam int EW = $clog2(REF_EDGES + 1);
    localparam int GW = $clog2(LOCK_WINDOWS + 1);

    localparam logic [CNT_WIDTH-1:0] TMO_CNT  = CNT_WIDTH'(2 * EXPECTED);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(2 * EXPECTED - 1);
    localparam logic [CNT_WIDTH-1:0] LO_LIM   =
        CNT_WIDTH'((EXPECTED > TOLERANCE) ? (EXPECTED - TOLERANCE) : 0);
    localparam logic [CNT_WIDTH-1:0] HI_LIM   = CNT_WIDTH'(EXPECTED + TOLERANCE);
    localparam logic [EW-1:0]        EDGE_LAST = EW'(REF_EDGES - 1);
    localparam logic [GW-1:0]        GOOD_MAX  = GW'(LOCK_WINDOWS);
    localparam logic [GW-1:0]        GOOD_PRE  = GW'(LOCK_WINDOWS - 1);

    typedef enum logic {SEEK, MEASURE} state_t;

    state_t                 state_q;
    logic                   s1_q, s2_q, s3_q, edge_q;
    logic [CNT_WIDTH-1:0]   cyc_q;
    logic [EW-1:0]          ecnt_q;
    logic [CNT_WIDTH-1:0]   meas_count_q;
    logic                   meas_valid_q;
    logic                   eval_good_q;
    logic [GW-1:0]          good_q;
    logic                   locked_q, fault_q;

    logic [CNT_WIDTH-1:0]   win_cnt_d;
    logic                   win_good_d;

    // Count for a window closing this cycle includes the closing cycle itself.
    assign win_cnt_d  = cyc_q + 1'b1;
    assign win_good_d = (win_cnt_d >= LO_LIM) && (win_cnt_d <= HI_LIM);

    // Two-flop synchronizer, history flop and registered rising-edge pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= ref_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            edge_q <= s2_q & ~s3_q;
        end
    end

    // Window FSM: seek first edge, then back-to-back windows until timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= SEEK;
            cyc_q        <= '0;
            ecnt_q       <= '0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            eval_good_q  <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state_q)
                SEEK: begin
                    cyc_q  <= '0;
                    ecnt_q <= '0;
                    if (edge_q) state_q <= MEASURE;
                end
                MEASURE: begin
                    if (cyc_q == TMO_LAST) begin
                        // Timeout beats a coincident edge; restart from SEEK.
                        meas_count_q <= TMO_CNT;
                        meas_valid_q <= 1'b1;
                        eval_good_q  <= 1'b0;
                        cyc_q        <= '0;
                        ecnt_q       <= '0;
                        state_q      <= SEEK;
                    end else if (edge_q && (ecnt_q == EDGE_LAST)) begin
                        // Close and start the next window on the same cycle.
                        meas_count_q <= win_cnt_d;
                        meas_valid_q <= 1'b1;
                        eval_good_q  <= win_good_d;
                        cyc_q        <= '0;
                        ecnt_q       <= '0;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                        if (edge_q) ecnt_q <= ecnt_q + 1'b1;
                    end
                end
                default: state_q <= SEEK;
            endcase
        end
    end

    // Lock tracking and sticky fault, one cycle behind the evaluation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            good_q   <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            if (meas_valid_q) begin
                if (eval_good_q) begin
                    if (good_q != GOOD_MAX) good_q <= good_q + 1'b1;
                    if (good_q >= GOOD_PRE) locked_q <= 1'b1;
                end else begin
                    good_q   <= '0;
                    locked_q <= 1'b0;
                end
            end
            // A fault being set outranks a simultaneous clear.
            if (meas_valid_q && !eval_good_q && locked_q) fault_q <= 1'b1;
            else if (fault_clear)                       fault_q <= 1'b0;
        end
    end

    assign locked     = locked_q;
    assign fault      = fault_q;
    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;

endmodule

// File: doc/clk_freq_monitor.md
# clk_freq_monitor

Frequency monitor and lock detector for the core clock produced by the clock-generation wrapper. It runs entirely in the core clock domain and treats the board reference clock as an asynchronous data input. It counts core cycles across a fixed number of reference periods, checks each count against an expected value, and reports `locked`/`fault` status to the SUMP control logic. Capture is only armed while `locked` is high.

## Interface
- `REF_EDGES`, default 32: reference rising edges per measurement window.
- `EXPECTED`, default 100: nominal core cycles per window (100 MHz core / 32 MHz reference × 32).
- `TOLERANCE`, default 2: allowed absolute deviation from `EXPECTED`.
- `LOCK_WINDOWS`, default 4: consecutive good windows required to assert `locked`.
- `CNT_WIDTH`, default 12: width of the cycle counter and `meas_count`. Must hold `2*EXPECTED`.
- `clock` input, 1 bit: core clock. All logic is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `ref_in` input, 1 bit: reference clock, asynchronous to `clock`.
- `fault_clear` input, 1 bit: single-cycle pulse that clears `fault`.
- `locked` output, 1 bit: core frequency is within tolerance.
- `fault` output, 1 bit: sticky flag; a bad window occurred while `locked` was high.
- `meas_count` output, `CNT_WIDTH` bits: count from the last completed or timed-out window.
- `meas_valid` output, 1 bit: one-cycle pulse when `meas_count` updates.

## Operation
- Synchronizer: `ref_in` passes through two flops (s1, s2) and then a history flop (s3).
- `ref_edge` = s2 & ~s3. It is registered, so there are 3 cycles from an `ref_in` rise to the `ref_edge` pulse.
- State machine, SEEK:
  - Cycle counter and edge counter are held at 0.
  - On `ref_edge`, go to MEASURE with cycle counter = 0 and edge counter = 0.
- State machine, MEASURE:
  - The cycle counter increments every cycle.
  - The edge counter increments on each `ref_edge`.
  - Window close: on the `ref_edge` that brings the edge counter to `REF_EDGES`:
    - `meas_count` <= cycle counter + 1;
    - `meas_valid` pulses;
    - the window is evaluated;
    - the next window starts on the same cycle: both counters reload to 0 and the state stays MEASURE, with no gap.
  - Timeout: if the cycle counter reaches `2*EXPECTED` before close:
    - `meas_count` <= `2*EXPECTED`;
    - `meas_valid` pulses;
    - the window is evaluated as bad;
    - the state returns to SEEK.
- Evaluation: a window is good iff |`meas_count` − `EXPECTED`| ≤ `TOLERANCE`. Use unsigned comparisons against `EXPECTED±TOLERANCE`; no signed arithmetic.
- Good window: the good-window counter increments and saturates at `LOCK_WINDOWS`. When it reaches `LOCK_WINDOWS`, `locked` <= 1.
- Bad window: the good-window counter <= 0 and `locked` <= 0. If `locked` was 1 on that cycle, `fault` <= 1.
- `fault_clear`: clears `fault`. If a fault-set and `fault_clear` occur on the same cycle, the set wins.
- Reset in any state:
  - counters and state return to SEEK/0 immediately;
  - all outputs go to 0;
  - any partial window is discarded.

## Timing
- Reset values: `locked`=0, `fault`=0, `meas_count`=0, `meas_valid`=0; state SEEK.
- `meas_count`, `meas_valid`, and the evaluation result all appear in the same cycle.
- `locked` and `fault` update one cycle after the `meas_valid` pulse.
- Minimum time from reset release to `locked` is (`LOCK_WINDOWS` + 1 partial) windows plus 3 synchronizer cycles. That is about 5 µs at defaults.
- Synchronizer quantization gives ±1 count jitter per window. `TOLERANCE` ≥ 1 is required.
- A `ref_edge` that coincides with timeout is ignored: timeout wins and the state returns to SEEK.

## Test plan
- Nominal, with `ref_in` generated synchronously to `clock` (2 high / 2 low, period 4 cycles), `EXPECTED`=128, `REF_EDGES`=32:
  - every `meas_count` = 128;
  - `locked` rises one cycle after the 4th `meas_valid`;
  - `fault` stays 0.
- Off-frequency: same setup with a period of 5 cycles → `meas_count` = 160 each window; `locked` never asserts; `fault` stays 0.
- Reference stop while locked: hold `ref_in` low after lock → `meas_valid` with `meas_count` = 256 exactly 256 cycles after the last window start; `locked` falls and `fault` rises the next cycle.
- Fault clear race: assert `fault_clear` on the same cycle a fault is set → `fault` = 1. A later lone `fault_clear` → `fault` = 0 the next cycle.
- Reset mid-window: assert `reset` at cycle 50 of a locked window → all outputs 0 immediately. After release, the first `meas_valid` comes one full window after the first `ref_edge`.
- Asynchronous 32 MHz reference vs 100 MHz `clock` at defaults → every `meas_count` ∈ {99, 100, 101}; `locked` asserted within 6 µs.
